my_dc_fifo: RTL and testbench



---
 rtl/my_dc_fifo.sv | 111 +++++++++++
 tb/tb_my_dc_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/my_dc_fifo.sv
// ---------------------------------------------------------------------------
// my_dc_fifo
//   Single-clock, mixed-width FIFO. Each 16-bit write word is stored whole.
//   It is read back as two bytes, low byte first. The FIFO links a 16-bit
//   producer to a byte-wide consumer. Reads are in normal (not show-ahead)
//   mode: q updates on the edge that accepts the read.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst_n    in   asynchronous active-low reset
//   data     in   WR_WIDTH   write word
//   wrreq    in   1          write request (ignored while wrfull)
//   rdreq    in   1          read request (ignored while rdempty)
//   q        out  WR_WIDTH/2 read byte, valid the cycle after an accepted read
//   rdempty  out  1          no bytes stored
//   rdusedw  out  AW+1       stored byte count, modulo 2*DEPTH_WORDS
//   wrfull   out  1          every word slot still holds an unread byte
//   wrusedw  out  AW         occupied word slots, modulo DEPTH_WORDS
// ---------------------------------------------------------------------------
module my_dc_fifo #(
    parameter int WR_WIDTH    = 16,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic [WR_WIDTH-1:0]              data,
    input  logic                             wrreq,
    input  logic                             rdreq,
    output logic [WR_WIDTH/2-1:0]            q,
    output logic                             rdempty,
    output logic [$clog2(DEPTH_WORDS):0]     rdusedw,
    output logic                             wrfull,
    output logic [$clog2(DEPTH_WORDS)-1:0]   wrusedw
);

    localparam int RD_W  = WR_WIDTH / 2;
    localparam int AW    = $clog2(DEPTH_WORDS);  // word address width
    localparam int RAW   = AW + 1;               // byte address width
    localparam int CW    = AW + 2;               // byte count 0..2*DEPTH_WORDS
    localparam int BYTES = 2 * DEPTH_WORDS;

    // Select the low or high half of a stored word.
    function automatic logic [RD_W-1:0] sel_byte(input logic [WR_WIDTH-1:0] w,
                                                 input logic               hi);
        return hi ? w[WR_WIDTH-1:RD_W] : w[RD_W-1:0];
    endfunction

    // Occupied word slots = ceil(bytes/2), truncated to the port width.
    // A half-read word still occupies its slot.
    function automatic logic [AW-1:0] ceil_half(input logic [CW-1:0] b);
        return AW'((b + CW'(1)) >> 1);
    endfunction

    logic [WR_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]       wr_ptr;
    logic [RAW-1:0]      rd_ptr;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                wr_acc;
    logic                rd_acc;

    // Flags come from the registered count only. Acceptance therefore
    // always sees the state from before the edge.
    assign rdempty = (cnt == '0);
    assign wrfull  = (cnt > CW'(BYTES - 2));
    assign rdusedw = cnt[RAW-1:0];
    assign wrusedw = ceil_half(cnt);

    assign wr_acc = wrreq && !wrfull;
    assign rd_acc = rdreq && !rdempty;

    always_comb begin
        cnt_nxt = cnt;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = cnt + CW'(2);
            2'b01:   cnt_nxt = cnt - CW'(1);
            2'b11:   cnt_nxt = cnt + CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // ---- stage p0: request acceptance, pointer and count update ----------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + RAW'(1);
            cnt <= cnt_nxt;
        end
    end

    // Storage is not reset. A read in the same cycle as a write sees the old
    // contents. A non-empty FIFO never has its read word targeted by the
    // write pointer, because wrfull blocks that case.
    always_ff @(posedge Clk) begin
        if (wr_acc) mem[wr_ptr] <= data;
    end

    // ---- stage p1: registered read byte ----------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q <= '0;
        end else if (rd_acc) begin
            q <= sel_byte(mem[rd_ptr[RAW-1:1]], rd_ptr[0]);
        end
    end

endmodule

// File: tb/tb_my_dc_fifo.sv
// ---------------------------------------------------------------------------
// tb_my_dc_fifo
//   Scoreboard bench for my_dc_fifo. Each accepted write pushes its two
//   expected bytes. Each accepted read pops one and compares it with q on the
//   following cycle. The byte count is tracked alongside and checked against
//   every flag and level after every cycle.
// ---------------------------------------------------------------------------
module tb_my_dc_fifo;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [15:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [7:0]  q;
    logic        rdempty;
    logic [8:0]  rdusedw;
    logic        wrfull;
    logic [7:0]  wrusedw;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    int          mcnt;
    logic [7:0]  mq;

    my_dc_fifo #(.WR_WIDTH(16), .DEPTH_WORDS(256)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .rdempty (rdempty),
        .rdusedw (rdusedw),
        .wrfull  (wrfull),
        .wrusedw (wrusedw)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_levels();
        check("rdempty", 32'(rdempty), 32'(mcnt == 0));
        check("wrfull",  32'(wrfull),  32'(mcnt > 510));
        check("rdusedw", 32'(rdusedw), 32'(mcnt % 512));
        check("wrusedw", 32'(wrusedw), 32'(((mcnt + 1) / 2) % 256));
    endtask

    // One clock cycle of stimulus. Inputs are driven 1 time unit after an
    // edge. Outputs are sampled 1 time unit after the next edge.
    task automatic step(input logic wr, input logic [15:0] d, input logic rd);
        logic wacc;
        logic racc;
        wrreq = wr;
        data  = d;
        rdreq = rd;
        wacc  = wr && (mcnt <= 510);
        racc  = rd && (mcnt != 0);
        if (racc) mq = sb.pop_front();
        if (wacc) begin
            sb.push_back(d[7:0]);
            sb.push_back(d[15:8]);
        end
        mcnt = mcnt + (wacc ? 2 : 0) - (racc ? 1 : 0);
        @(posedge Clk);
        #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        check("q", 32'(q), 32'(mq));
        check_levels();
    endtask

    initial begin
        Rst_n = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        mcnt  = 0;
        mq    = 8'h00;

        // Reset held for 5 cycles.
        repeat (5) @(posedge Clk);
        #1;
        check("reset_q", 32'(q), 32'h0);
        check_levels();
        Rst_n = 1'b1;

        // Fill with 256 words. The per-cycle checks cover 1, 255 and 256 words.
        for (int i = 0; i < 256; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0);
        check("fill_full", 32'(wrfull), 32'h1);

        // Overflow: this write must be dropped.
        step(1'b1, 16'hFFFF, 1'b0);
        check("ovf_sb_bytes", 32'(sb.size()), 32'd512);

        // Drain all 512 bytes, low byte first.
        for (int i = 0; i < 512; i++) step(1'b0, 16'h0000, 1'b1);
        check("drain_last_q", 32'(q), 32'h04);

        // Underflow: q holds its last value.
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
        check("udf_hold_q", 32'(q), 32'h04);

        // Concurrent read and write, starting with 4 bytes stored.
        step(1'b1, 16'h1100, 1'b0);
        step(1'b1, 16'h2322, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, {4'hC, 4'(i), 4'hD, 4'(i)}, 1'b1);
        check("conc_rdusedw", 32'(rdusedw), 32'd14);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0000, 1'b1);
        check("conc_empty", 32'(rdempty), 32'h1);

        // Reset in the middle of a cycle takes effect immediately.
        step(1'b1, 16'h5A5A, 1'b0);
        step(1'b1, 16'h6B6B, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        sb.delete();
        mcnt = 0;
        mq   = 8'h00;
        check("async_rst_q", 32'(q), 32'h0);
        check_levels();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Normal operation resumes after reset.
        step(1'b1, 16'h7788, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("post_rst_q", 32'(q), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
